ps2_key_decoder: RTL and testbench
==================================

# ps2_key_decoder

Consumes raw PS/2 set-2 scan bytes from the keyboard receiver (`ps2Interface`) and converts them into ASCII characters in the system clock domain. The block:
- synchronizes the receiver's byte strobe;
- tracks break (`F0`) and extended (`E0`) prefixes and the shift state;
- pushes make-code characters into a first-word-fall-through FIFO that the CPU I/O port drains with a ready/valid handshake.

It sits between the keyboard receiver and the memory-mapped keyboard register.

## Interface
Parameters:
- `WORD_SIZE`, default `gc::WORD_SIZE`: width of `rdData`; ASCII is zero-extended.
- `FIFO_DEPTH`, default 8: character FIFO depth; must be a power of 2, at least 2.

Ports:
- `clk` input 1: system clock. One clock; all state is on the rising edge.
- `resetN` input 1: reset, asynchronous, active-low.
- `scanCode` input 8: byte from the receiver, in the `kbdClk` domain. Stable for at least 4 `clk` cycles after `scanValid` rises.
- `scanValid` input 1: receiver byte-complete level, in the `kbdClk` domain.
- `scanError` input 1: receiver parity error, in the `kbdClk` domain. Sampled together with `scanCode`.
- `rdReady` input 1: consumer pops the head entry when `rdValid` is also high.
- `clrOverflow` input 1: synchronous clear of `overflow`.
- `rdData` output `WORD_SIZE`: FIFO head, zero-extended ASCII. Equals 0 when the FIFO is empty.
- `rdValid` output 1: FIFO not empty.
- `count` output `$clog2(FIFO_DEPTH)+1`: number of entries in the FIFO.
- `overflow` output 1: sticky flag; set when a character is dropped because the FIFO is full.
- `shiftActive` output 1: left or right shift is currently held.
- `errCount` output 8: number of parity-errored bytes; saturates at 255.

## Operation
- **Byte capture**
  - `scanValid` passes through a 2-flop synchronizer, then a rising-edge detector.
  - On a detected edge, the block captures `scanCode` and `scanError`; this is one "accepted byte".
- **Error bytes**: if the captured `scanError` = 1, the byte is discarded, the FSM goes to IDLE, and `errCount` increments (saturating at 255).
- **FSM**, with states IDLE, BRK, EXT, EXTBRK. Transitions per accepted byte:
  - IDLE:
    - `F0` → BRK
    - `E0` → EXT
    - `12` or `59` (left/right shift make) → set the corresponding shift bit; stay in IDLE
    - any other byte → translate and push if the mapping is nonzero; stay in IDLE
  - BRK:
    - `12` or `59` → clear the corresponding shift bit
    - any other byte → ignored
    - next state is always IDLE
  - EXT: `F0` → EXTBRK; any other byte → ignored, next state IDLE. Extended keys produce no characters.
  - EXTBRK: any byte → IDLE, no action.
- **Translation**
  - Letters map to lowercase ASCII, or uppercase when `shiftActive`. Example: `1C` → `a`/`A`.
  - Digits `45,16,1E,26,25,2E,36,3D,3E,46` map to `0`–`9`, or to `)!@#$%^&*(` when shifted.
  - `29` → 0x20, `5A` → 0x0D, `66` → 0x08.
  - All other codes map to 0 and are not pushed.
- `shiftActive` = left shift bit OR right shift bit.
- **FIFO**
  - Circular buffer with separate read and write pointers of `$clog2(FIFO_DEPTH)` bits; both wrap modulo `FIFO_DEPTH`.
  - `count` is tracked explicitly.
  - A push when `count == FIFO_DEPTH` and no pop in the same cycle: the character is dropped and `overflow` is set.
  - Simultaneous push and pop when full: both happen, `count` is unchanged, no overflow.
  - Simultaneous push and pop when empty: only the push happens; the pop is ignored because `rdValid` = 0.
  - `clrOverflow` clears `overflow`. If a drop occurs in the same cycle as `clrOverflow`, the flag is set (set wins).

## Timing
- Reset values:
  - `rdData` = 0, `rdValid` = 0, `count` = 0, `overflow` = 0, `shiftActive` = 0, `errCount` = 0.
  - FSM in IDLE, pointers = 0, synchronizer flops = 0.
- Reset asserted mid-operation: all of the above take effect immediately and asynchronously. FIFO contents are lost and no partial prefix state survives.
- Latency, numbering rising `clk` edges from the first edge that samples `scanValid` = 1 as edge 1:
  - sync2 = 1 after edge 2;
  - byte accepted, and FSM/shift state updated, at edge 3;
  - FIFO written at edge 4;
  - `rdValid` and `rdData` valid after edge 4.
- The FIFO is first-word-fall-through: `rdData` shows the head combinationally from the storage and read pointer.
- A pop at edge k shows the next entry (or 0 and `rdValid` = 0) after edge k.
- `scanValid` held high produces exactly one accepted byte. A new byte requires `scanValid` to go low for at least 2 `clk` cycles first.

## Test plan
- Reset, then feed `1C` → after edge 4: `rdValid` = 1, `rdData` = 0x61, `count` = 1. Pop once → `rdValid` = 0, `rdData` = 0.
- Feed `12, 1C, F0 1C, F0 12, 1C` → FIFO holds 0x41 then 0x61. `shiftActive` is 1 between the `12` make and its `F0 12` break.
- Feed `E0 75, E0 F0 75, 16` → FIFO holds only 0x31; FSM returns to IDLE after each sequence.
- Feed a byte with `scanError` = 1 (code `1C`), then `1E` → `errCount` = 1, FIFO holds only 0x32.
- With `FIFO_DEPTH` = 8, push 9 characters with no reads → `count` = 8, `overflow` = 1, and the 9th is lost.
  - Then pulse `clrOverflow` → `overflow` = 0.
  - Then, while full, push and pop in the same cycle → `count` stays 8, `overflow` stays 0, and the read pointer wraps correctly.
- Assert `resetN` low while `count` = 3 and the FSM is in BRK → all outputs return to reset values immediately. A following `1C` yields 0x61, so no stale break is applied.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan byte decoder: synchronizes the receiver strobe, tracks break/extended
// prefixes and shift state, and queues ASCII characters in a first-word-fall-through FIFO.
package gc;
  localparam int WORD_SIZE = 16;
endpackage

module ps2_key_decoder #(
  parameter int WORD_SIZE  = gc::WORD_SIZE,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic [7:0]                    scanCode,
  input  logic                          scanValid,
  input  logic                          scanError,
  input  logic                          rdReady,
  input  logic                          clrOverflow,
  output logic [WORD_SIZE-1:0]          rdData,
  output logic                          rdValid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          shiftActive,
  output logic [7:0]                    errCount
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXTBRK} state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync2_q, sync3_q;
  logic            shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic            push_q, push_d;
  logic [7:0]      char_q, char_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            ovf_q, ovf_d;
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     count_q, count_d;
  logic [7:0]      mem [FIFO_DEPTH];
  logic            accept, pop, push_ok, drop;
  logic [7:0]      ascii;

  function automatic logic [7:0] xlate(input logic [7:0] code, input logic shift);
    logic [7:0] lower;
    logic [7:0] digit_sh;
    lower    = 8'h00;
    digit_sh = 8'h00;
    case (code)
      8'h1C: lower = "a";  8'h32: lower = "b";  8'h21: lower = "c";  8'h23: lower = "d";
      8'h24: lower = "e";  8'h2B: lower = "f";  8'h34: lower = "g";  8'h33: lower = "h";
      8'h43: lower = "i";  8'h3B: lower = "j";  8'h42: lower = "k";  8'h4B: lower = "l";
      8'h3A: lower = "m";  8'h31: lower = "n";  8'h44: lower = "o";  8'h4D: lower = "p";
      8'h15: lower = "q";  8'h2D: lower = "r";  8'h1B: lower = "s";  8'h2C: lower = "t";
      8'h3C: lower = "u";  8'h2A: lower = "v";  8'h1D: lower = "w";  8'h22: lower = "x";
      8'h35: lower = "y";  8'h1A: lower = "z";
      8'h45: begin lower = "0"; digit_sh = ")"; end
      8'h16: begin lower = "1"; digit_sh = "!"; end
      8'h1E: begin lower = "2"; digit_sh = "@"; end
      8'h26: begin lower = "3"; digit_sh = "#"; end
      8'h25: begin lower = "4"; digit_sh = "$"; end
      8'h2E: begin lower = "5"; digit_sh = "%"; end
      8'h36: begin lower = "6"; digit_sh = "^"; end
      8'h3D: begin lower = "7"; digit_sh = "&"; end
      8'h3E: begin lower = "8"; digit_sh = "*"; end
      8'h46: begin lower = "9"; digit_sh = "("; end
      8'h29: lower = 8'h20;
      8'h5A: lower = 8'h0D;
      8'h66: lower = 8'h08;
      default: lower = 8'h00;
    endcase
    if (shift && digit_sh != 8'h00)                  return digit_sh;
    else if (shift && lower >= "a" && lower <= "z") return lower - 8'h20;
    else                                            return lower;
  endfunction

  assign accept      = sync2_q & ~sync3_q;
  assign shiftActive = shift_l_q | shift_r_q;
  assign ascii       = xlate(scanCode, shiftActive);

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    shift_l_d = shift_l_q;
    shift_r_d = shift_r_q;
    push_d    = 1'b0;
    char_d    = 8'h00;
    err_cnt_d = err_cnt_q;
    if (accept) begin
      if (scanError) begin
        state_d = IDLE;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end else begin
        case (state_q)
          IDLE: begin
            case (scanCode)
              8'hF0:   state_d = BRK;
              8'hE0:   state_d = EXT;
              8'h12:   shift_l_d = 1'b1;
              8'h59:   shift_r_d = 1'b1;
              default: begin
                push_d = (ascii != 8'h00);
                char_d = ascii;
              end
            endcase
          end
          BRK: begin
            if (scanCode == 8'h12) shift_l_d = 1'b0;
            if (scanCode == 8'h59) shift_r_d = 1'b0;
            state_d = IDLE;
          end
          EXT:     state_d = (scanCode == 8'hF0) ? EXTBRK : IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  assign rdValid  = (count_q != '0);
  assign pop      = rdReady & rdValid;
  assign push_ok  = push_q & ((count_q != FULL) | pop);
  assign drop     = push_q & (count_q == FULL) & ~pop;
  assign ovf_d    = drop | (ovf_q & ~clrOverflow);
  assign rdData   = rdValid ? WORD_SIZE'(mem[rptr_q]) : '0;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign errCount = err_cnt_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
      shift_l_q <= 1'b0;
      shift_r_q <= 1'b0;
      push_q    <= 1'b0;
      char_q    <= 8'h00;
      err_cnt_q <= 8'h00;
      ovf_q     <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= scanValid;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      shift_l_q <= shift_l_d;
      shift_r_q <= shift_r_d;
      push_q    <= push_d;
      char_q    <= char_d;
      err_cnt_q <= err_cnt_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
    end
  end

  // NOTE: storage is not reset; an empty count masks stale entries from rdData.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= char_q;
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder with hand-computed expected characters.
module tb_ps2_key_decoder;

  localparam int WS = 16;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic [7:0]    scanCode = 8'h00;
  logic          scanValid = 1'b0;
  logic          scanError = 1'b0;
  logic          rdReady = 1'b0;
  logic          clrOverflow = 1'b0;
  logic [WS-1:0] rdData;
  logic          rdValid;
  logic [3:0]    count;
  logic          overflow;
  logic          shiftActive;
  logic [7:0]    errCount;

  int n_pass  = 0;
  int n_total = 0;

  ps2_key_decoder #(.WORD_SIZE(WS), .FIFO_DEPTH(8)) dut (
    .clk(clk), .resetN(resetN), .scanCode(scanCode), .scanValid(scanValid),
    .scanError(scanError), .rdReady(rdReady), .clrOverflow(clrOverflow),
    .rdData(rdData), .rdValid(rdValid), .count(count), .overflow(overflow),
    .shiftActive(shiftActive), .errCount(errCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Byte strobe held for 4 clk edges, then low for 3 so the next byte is a fresh edge.
  task automatic send(input logic [7:0] code, input logic err = 1'b0);
    @(negedge clk);
    scanCode  = code;
    scanError = err;
    scanValid = 1'b1;
    repeat (4) @(negedge clk);
    scanValid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Same strobe, with rdReady high exactly for the FIFO write edge (edge 4).
  task automatic send_with_pop(input logic [7:0] code);
    @(negedge clk);
    scanCode  = code;
    scanError = 1'b0;
    scanValid = 1'b1;
    repeat (3) @(negedge clk);
    rdReady = 1'b1;
    @(negedge clk);
    rdReady   = 1'b0;
    scanValid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk);
    rdReady = 1'b1;
    @(negedge clk);
    rdReady = 1'b0;
  endtask

  task automatic expect_head(input string tag, input logic [7:0] ch);
    check({tag, "_valid"}, 32'(rdValid), 32'd1);
    check({tag, "_data"},  32'(rdData),  32'(ch));
    pop_one();
  endtask

  logic [7:0] fill_codes [9];
  logic [7:0] drain_chars [8];

  initial begin
    fill_codes  = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
    drain_chars = '{"b", "c", "d", "e", "f", "g", "h", "j"};

    #12;
    check("rst_rdValid",  32'(rdValid),     32'd0);
    check("rst_rdData",   32'(rdData),      32'd0);
    check("rst_count",    32'(count),       32'd0);
    check("rst_overflow", 32'(overflow),    32'd0);
    check("rst_shift",    32'(shiftActive), 32'd0);
    check("rst_errCount", 32'(errCount),    32'd0);
    @(negedge clk);
    resetN = 1'b1;
    repeat (2) @(negedge clk);

    // Latency: nothing visible after edge 3, character after edge 4.
    scanCode  = 8'h1C;
    scanValid = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("lat_edge3_valid", 32'(rdValid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_edge4_valid", 32'(rdValid), 32'd1);
    check("lat_edge4_data",  32'(rdData),  32'h61);
    check("lat_edge4_count", 32'(count),   32'd1);
    @(negedge clk);
    scanValid = 1'b0;
    repeat (6) @(negedge clk);
    check("hold_one_byte", 32'(count), 32'd1);
    pop_one();
    check("pop_empty_valid", 32'(rdValid), 32'd0);
    check("pop_empty_data",  32'(rdData),  32'd0);

    // Shift tracking and shifted letters/digits.
    send(8'h12);
    check("shift_on", 32'(shiftActive), 32'd1);
    send(8'h1C);
    send(8'h16);
    send(8'hF0); send(8'h1C);
    check("shift_kept_after_letter_break", 32'(shiftActive), 32'd1);
    send(8'hF0); send(8'h12);
    check("shift_off", 32'(shiftActive), 32'd0);
    send(8'h1C);
    check("shift_count", 32'(count), 32'd3);
    expect_head("shift_A", "A");
    expect_head("shift_bang", "!");
    expect_head("shift_a", "a");
    send(8'h59);
    check("rshift_on", 32'(shiftActive), 32'd1);
    send(8'h45);
    send(8'hF0); send(8'h59);
    check("rshift_off", 32'(shiftActive), 32'd0);
    send(8'h29);
    expect_head("rshift_paren", ")");
    expect_head("space", 8'h20);

    // Extended sequences produce nothing and return to IDLE.
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'h16);
    check("ext_count", 32'(count), 32'd1);
    expect_head("ext_1", "1");
    check("ext_drained", 32'(rdValid), 32'd0);

    // Parity-errored byte is dropped and counted.
    send(8'h1C, 1'b1);
    send(8'h1E);
    check("err_count", 32'(errCount), 32'd1);
    check("err_fifo_count", 32'(count), 32'd1);
    expect_head("err_2", "2");

    // Overflow: 9 pushes into an 8-deep FIFO.
    foreach (fill_codes[i]) send(fill_codes[i]);
    check("ovf_count", 32'(count), 32'd8);
    check("ovf_flag",  32'(overflow), 32'd1);
    check("ovf_head",  32'(rdData), 32'h61);
    @(negedge clk);
    clrOverflow = 1'b1;
    @(negedge clk);
    clrOverflow = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Simultaneous push and pop while full.
    send_with_pop(8'h3B);
    check("full_pushpop_count", 32'(count), 32'd8);
    check("full_pushpop_ovf",   32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) expect_head($sformatf("drain%0d", i), drain_chars[i]);
    check("drain_empty_valid", 32'(rdValid), 32'd0);
    check("drain_empty_data",  32'(rdData),  32'd0);

    // Asynchronous reset mid-break with 3 entries queued and shift held.
    send(8'h12);
    send(8'h1C); send(8'h1C); send(8'h1C);
    send(8'hF0);
    check("pre_rst_count", 32'(count), 32'd3);
    check("pre_rst_shift", 32'(shiftActive), 32'd1);
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    check("arst_count",    32'(count),       32'd0);
    check("arst_valid",    32'(rdValid),     32'd0);
    check("arst_data",     32'(rdData),      32'd0);
    check("arst_shift",    32'(shiftActive), 32'd0);
    check("arst_errCount", 32'(errCount),    32'd0);
    check("arst_overflow", 32'(overflow),    32'd0);
    @(negedge clk);
    resetN = 1'b1;
    repeat (2) @(negedge clk);
    send(8'h1C);
    check("post_rst_count", 32'(count), 32'd1);
    expect_head("post_rst_a", "a");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
